// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for a DEPTH-cycle pipelined shift unit.
// Define SHIFT_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/1).
module shift_arbiter #(
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_opA,
    input  logic [1:0][4:0]  req_opB,
    input  logic [1:0][1:0]  req_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0][31:0] rsp_result,
    output logic [31:0]      sh_opA,
    output logic [4:0]       sh_opB,
    output logic [1:0]       sh_op,
    input  logic [31:0]      sh_result
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q [2];
    state_t           state_d [2];
    logic             ptr_q;
    logic [DEPTH-1:0] pv_q;
    logic [DEPTH-1:0] ptag_q;
    logic [1:0]       elig;
    logic             gnt_any;
    logic             gnt_idx;
    logic             cap;
    logic             cap_tag;

    // Grant path is gated by reset so nothing issues while reset is held.
    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            elig[r] = req_valid[r] && (state_q[r] == IDLE);
        end
        gnt_any   = !reset && (elig != 2'b00);
        gnt_idx   = (elig == 2'b11) ? ptr_q : elig[1];
        req_ready = '0;
        sh_opA    = '0;
        sh_opB    = '0;
        sh_op     = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            sh_opA             = req_opA[gnt_idx];
            sh_opB             = req_opB[gnt_idx];
            sh_op              = req_op[gnt_idx];
        end
    end

    assign cap     = pv_q[DEPTH-1];
    assign cap_tag = ptag_q[DEPTH-1];

    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            state_d[r]   = state_q[r];
            rsp_valid[r] = (state_q[r] == DONE);
            case (state_q[r])
                IDLE:    if (gnt_any && (gnt_idx == r[0])) state_d[r] = BUSY;
                BUSY:    if (cap && (cap_tag == r[0]))     state_d[r] = DONE;
                DONE:    if (rsp_ready[r])                 state_d[r] = IDLE;
                default: state_d[r] = IDLE;
            endcase
        end
    end

    // Clearing the valid pipeline on reset drops any result still in the shift unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 2; r++) begin
                state_q[r] <= IDLE;
            end
            ptr_q      <= 1'b0;
            pv_q       <= '0;
            ptag_q     <= '0;
            rsp_result <= '0;
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                state_q[r] <= state_d[r];
            end
            if (gnt_any) begin
                ptr_q <= ~gnt_idx;
            end
            pv_q[0]   <= gnt_any;
            ptag_q[0] <= gnt_idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pv_q[i]   <= pv_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
            end
            if (cap) begin
                rsp_result[cap_tag] <= sh_result;
            end
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (gnt_any) begin
            if (!gnt_idx && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (gnt_idx && (grant_cnt1 != '1))  grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
